// File: rtl/audio_pkg.sv
// audio_pkg: shared state encoding and index/gain helpers for the audio routing blocks.
package audio_pkg;
  typedef enum logic [2:0] {PASS, FADE_OUT, SWITCH, FADE_IN, MUTED} state_t;
  function automatic int gain_full(input int ramp_shift);
    return 1 << ramp_shift;
  endfunction
  function automatic int ch_lo(input int s, input int c, input int num_ch, input int data_w);
    return (s * num_ch + c) * data_w;
  endfunction
endpackage

// File: rtl/audio_gain_stage.sv
// audio_gain_stage: registered per-channel signed sample x unsigned gain, arithmetic shift, truncate.
module audio_gain_stage
  import audio_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 24,
  parameter int RAMP_SHIFT = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [RAMP_SHIFT:0]      gain,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data
);
  localparam int PW = DATA_W + RAMP_SHIFT + 2;
  always_ff @(posedge clk)
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        for (int c = 0; c < NUM_CH; c++)
          out_data[ch_lo(0, c, NUM_CH, DATA_W) +: DATA_W] <=
            DATA_W'((PW'($signed(in_data[ch_lo(0, c, NUM_CH, DATA_W) +: DATA_W])) *
                     PW'($signed({1'b0, gain}))) >>> RAMP_SHIFT);
    end
endmodule

// File: rtl/audio_source_router.sv
// audio_source_router: click-free NUM_SRC-way multichannel PCM source select with linear gain ramps.
// Define AUDIO_ROUTER_PEAK_EN to add per-channel output peak meters (peak, peak_clr).
module audio_source_router
  import audio_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int NUM_CH = 2,
  parameter int DATA_W = 24,
  parameter int RAMP_SHIFT = 6
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_SRC-1:0]               src_valid,
  input  logic [NUM_SRC*NUM_CH*DATA_W-1:0] src_data,
  input  logic [3:0]                       sel,
  input  logic                             sel_load,
  input  logic                             mute,
  output logic                             out_valid,
  output logic [NUM_CH*DATA_W-1:0]         out_data,
  output logic [3:0]                       cur_sel,
  output logic                             busy,
  output logic                             sel_err
`ifdef AUDIO_ROUTER_PEAK_EN
  ,
  input  logic                             peak_clr,
  output logic [NUM_CH*DATA_W-1:0]         peak
`endif
);
  localparam int GAIN_W = RAMP_SHIFT + 1;
  localparam int SW = NUM_CH * DATA_W;
  localparam logic [GAIN_W-1:0] FULL = GAIN_W'(gain_full(RAMP_SHIFT));
  state_t state;
  logic [GAIN_W-1:0] gain, g1;
  logic [3:0] target, nt;
  logic sv, acc, load_ok, leave, v1;
  logic [SW-1:0] sd, d1;
  always_comb begin
    sv = 1'b0;
    sd = '0;
    for (int s = 0; s < NUM_SRC; s++)
      if (cur_sel == 4'(s)) begin
        sv = src_valid[s];
        sd = src_data[ch_lo(s, 0, NUM_CH, DATA_W) +: SW];
      end
  end
  assign load_ok = sel_load && int'(sel) < NUM_SRC;
  assign nt = load_ok ? sel : target;
  assign acc = sv && state != SWITCH;
  assign leave = mute || (load_ok && sel != cur_sel);
  assign busy = state != PASS && state != MUTED;
  // gain only moves on accepted samples of cur_sel, so ramp length is counted in samples
  always_ff @(posedge clk)
    if (reset) begin
      state <= FADE_IN;
      gain <= '0;
      target <= '0;
      cur_sel <= '0;
      sel_err <= 1'b0;
    end else begin
      target <= nt;
      if (sel_load && !load_ok) sel_err <= 1'b1;
      case (state)
        PASS: if (leave) state <= FADE_OUT;
        FADE_OUT: begin
          if (acc && gain != '0) gain <= gain - 1'b1;
          if (gain == '0 || (acc && gain == GAIN_W'(1))) state <= mute ? MUTED : SWITCH;
        end
        SWITCH: begin
          cur_sel <= nt;
          state <= FADE_IN;
        end
        FADE_IN:
          if (leave) state <= FADE_OUT;
          else if (acc) begin
            gain <= gain + 1'b1;
            if (gain == FULL - 1'b1) state <= PASS;
          end
        MUTED: if (!mute) state <= SWITCH;
        default: state <= FADE_IN;
      endcase
    end
  always_ff @(posedge clk)
    if (reset) begin
      v1 <= 1'b0;
      d1 <= '0;
      g1 <= '0;
    end else begin
      v1 <= acc;
      if (acc) begin
        d1 <= sd;
        g1 <= gain;
      end
    end
  audio_gain_stage #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RAMP_SHIFT(RAMP_SHIFT)) u_gain (
    .clk(clk),
    .reset(reset),
    .in_valid(v1),
    .in_data(d1),
    .gain(g1),
    .out_valid(out_valid),
    .out_data(out_data)
  );
`ifdef AUDIO_ROUTER_PEAK_EN
  for (genvar c = 0; c < NUM_CH; c++) begin : g_peak
    logic signed [DATA_W-1:0] o;
    logic [DATA_W-1:0] mag, pk;
    assign o = out_data[ch_lo(0, c, NUM_CH, DATA_W) +: DATA_W];
    assign mag = o == {1'b1, {(DATA_W-1){1'b0}}} ? {1'b0, {(DATA_W-1){1'b1}}} : (o[DATA_W-1] ? -o : o);
    assign peak[ch_lo(0, c, NUM_CH, DATA_W) +: DATA_W] = pk;
    always_ff @(posedge clk)
      if (reset) pk <= '0;
      else if (peak_clr) pk <= out_valid ? mag : '0;
      else if (out_valid && mag > pk) pk <= mag;
  end
`endif
endmodule

// File: tb/tb_audio_source_router.sv
// tb_audio_source_router: scoreboard bench for ramps, switching, mute, sel errors, latency and reset.
module tb_audio_source_router;
  localparam int NS = 4, NC = 2, W = 24, RS = 2;
  logic clk = 1'b0, reset;
  logic [NS-1:0] src_valid;
  logic [NS*NC*W-1:0] src_data;
  logic [3:0] sel, cur_sel;
  logic sel_load, mute, out_valid, busy, sel_err;
  logic [NC*W-1:0] out_data;
  int cyc = 0, passed = 0, total = 0;
  typedef struct {logic [NC*W-1:0] data; int at;} exp_t;
  exp_t sb[$];
  audio_source_router #(.NUM_SRC(NS), .NUM_CH(NC), .DATA_W(W), .RAMP_SHIFT(RS)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data), .sel(sel),
    .sel_load(sel_load), .mute(mute), .out_valid(out_valid), .out_data(out_data),
    .cur_sel(cur_sel), .busy(busy), .sel_err(sel_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [W-1:0] scale(input int v, input int g);
    longint p;
    p = longint'(v) * g;
    return W'(p >>> RS);
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) chk("spurious out_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("latency", cyc, e.at);
      end
    end
  end
  task automatic send(input int s, input int v0, input int v1, input int g);
    @(posedge clk);
    #1;
    src_data[(s*NC)*W +: W] = W'(v0);
    src_data[(s*NC+1)*W +: W] = W'(v1);
    src_valid[s] = 1'b1;
    if (g >= 0) sb.push_back('{{scale(v1, g), scale(v0, g)}, cyc + 2});
    @(posedge clk);
    #1;
    src_valid = '0;
    repeat (6) @(posedge clk);
  endtask
  task automatic load(input int s);
    @(posedge clk);
    #1;
    sel = 4'(s);
    sel_load = 1'b1;
    @(posedge clk);
    #1;
    sel_load = 1'b0;
  endtask
  task automatic set_mute(input logic m);
    @(posedge clk);
    #1;
    mute = m;
    repeat (3) @(posedge clk);
  endtask
  initial begin
    int bv0[3] = '{-'h800000, 'h123456, 'h400000};
    int bv1[3] = '{'h7FFFFF, -'h123456, -'h400000};
    reset = 1'b1;
    src_valid = '0;
    src_data = '0;
    sel = '0;
    sel_load = 1'b0;
    mute = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset cur_sel", cur_sel, 0);
    chk("reset sel_err", sel_err, 0);
    chk("reset busy", busy, 1);
    reset = 1'b0;
    for (int g = 0; g < 4; g++) send(0, 'h400000, -'h400000, g);
    chk("startup busy", busy, 0);
    send(0, 'h400000, -'h400000, 4);
    chk("startup cur_sel", cur_sel, 0);
    load(2);
    chk("fade_out busy", busy, 1);
    for (int g = 4; g > 0; g--) send(0, 'h400000, -'h400000, g);
    for (int g = 0; g <= 4; g++) send(2, -'h400000, 'h400000, g);
    chk("switch cur_sel", cur_sel, 2);
    chk("switch busy", busy, 0);
    load(1);
    for (int g = 4; g > 0; g--) send(2, -'h400000, 'h400000, g);
    send(1, 'h200000, -'h200000, 0);
    load(3);
    send(1, 'h200000, -'h200000, 1);
    chk("retarget cur_sel", cur_sel, 3);
    for (int g = 0; g <= 4; g++) send(3, 'h200000, -'h200000, g);
    set_mute(1'b1);
    for (int g = 4; g > 0; g--) send(3, 'h200000, -'h200000, g);
    send(3, 'h200000, -'h200000, 0);
    send(3, 'h200000, -'h200000, 0);
    chk("muted busy", busy, 0);
    set_mute(1'b0);
    for (int g = 0; g <= 4; g++) send(3, 'h200000, -'h200000, g);
    chk("unmute cur_sel", cur_sel, 3);
    load(9);
    chk("bad sel sel_err", sel_err, 1);
    chk("bad sel busy", busy, 0);
    send(0, 'h300000, -'h300000, -1);
    send(3, 'h200000, -'h200000, 4);
    chk("bad sel cur_sel", cur_sel, 3);
    @(posedge clk);
    #1;
    sel = 4'd0;
    sel_load = 1'b1;
    mute = 1'b1;
    @(posedge clk);
    #1;
    sel_load = 1'b0;
    for (int g = 4; g > 0; g--) send(3, 'h200000, -'h200000, g);
    send(3, 'h200000, -'h200000, 0);
    chk("mute+load cur_sel", cur_sel, 3);
    set_mute(1'b0);
    for (int g = 0; g <= 4; g++) send(0, 'h400000, -'h400000, g);
    chk("mute+load target", cur_sel, 0);
    chk("sel_err sticky", sel_err, 1);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      src_data[0 +: W] = W'(bv0[i]);
      src_data[W +: W] = W'(bv1[i]);
      src_valid[0] = 1'b1;
      sb.push_back('{{scale(bv1[i], 4), scale(bv0[i], 4)}, cyc + 2});
      @(posedge clk);
    end
    #1;
    src_valid = '0;
    repeat (6) @(posedge clk);
    load(1);
    send(0, 'h400000, -'h400000, 4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midramp reset cur_sel", cur_sel, 0);
    chk("midramp reset sel_err", sel_err, 0);
    chk("midramp reset busy", busy, 1);
    chk("midramp reset out_valid", out_valid, 0);
    reset = 1'b0;
    send(0, 'h400000, -'h400000, 0);
    send(0, 'h400000, -'h400000, 1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
